// File: rtl/crossbar_in_if.sv
// Request/bank bundle for crossbar_in: per-PE request ports, per-bank registered outputs.
// The configuration requester signals exist only when XBAR_CONF_PORT_EN is defined.
interface crossbar_in_if #(
    parameter int NUM_PE     = 4,
    parameter int NUM_BANK   = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int BANK_W  = $clog2(NUM_BANK);
    localparam int BADDR_W = ADDR_WIDTH - BANK_W;
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int PTR_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
`ifdef XBAR_CONF_PORT_EN
    localparam int PEID_W  = NUM_PE + 1;
`else
    localparam int PEID_W  = NUM_PE;
`endif

    // Handshake: i_req[p] is the valid, o_gnt[p] the combinational ready. The
    // requester holds i_req[p] and its payload stable until the cycle where
    // i_req[p] & o_gnt[p]; that cycle consumes it. Dropping i_req[p] earlier
    // withdraws the request with no side effects.
    logic [NUM_PE-1:0]                  i_req;
    logic [NUM_PE-1:0]                  i_we;
    logic [NUM_PE-1:0][ADDR_WIDTH-1:0]  i_addr;
    logic [NUM_PE-1:0][DATA_WIDTH-1:0]  i_wdata;
    logic [NUM_PE-1:0][STRB_W-1:0]      i_wstrb;
    logic [NUM_PE-1:0]                  o_gnt;

    logic [NUM_BANK-1:0]                o_bank_en;
    logic [NUM_BANK-1:0]                o_bank_we;
    logic [NUM_BANK-1:0][BADDR_W-1:0]   o_bank_addr;
    logic [NUM_BANK-1:0][DATA_WIDTH-1:0] o_bank_wdata;
    logic [NUM_BANK-1:0][STRB_W-1:0]    o_bank_wstrb;
    logic [NUM_BANK-1:0][PEID_W-1:0]    o_bank_peID;

    // Round-robin pointers, exposed for observation only.
    logic [NUM_BANK-1:0][PTR_W-1:0]     o_dbg_rr_ptr;

`ifdef XBAR_CONF_PORT_EN
    logic                               i_conf_req;
    logic                               i_conf_we;
    logic [ADDR_WIDTH-1:0]              i_conf_addr;
    logic [DATA_WIDTH-1:0]              i_conf_wdata;
    logic [STRB_W-1:0]                  i_conf_wstrb;
    logic                               o_conf_gnt;
`endif

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_wstrb,
`ifdef XBAR_CONF_PORT_EN
        input  i_conf_req, i_conf_we, i_conf_addr, i_conf_wdata, i_conf_wstrb,
        output o_conf_gnt,
`endif
        output o_gnt, o_bank_en, o_bank_we, o_bank_addr, o_bank_wdata,
        output o_bank_wstrb, o_bank_peID, o_dbg_rr_ptr
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_wstrb,
`ifdef XBAR_CONF_PORT_EN
        output i_conf_req, i_conf_we, i_conf_addr, i_conf_wdata, i_conf_wstrb,
        input  o_conf_gnt,
`endif
        input  o_gnt, o_bank_en, o_bank_we, o_bank_addr, o_bank_wdata,
        input  o_bank_wstrb, o_bank_peID, o_dbg_rr_ptr
    );
endinterface

// File: rtl/crossbar_in.sv
// Request-side crossbar: per-bank round-robin arbitration of PE requests onto
// word-interleaved SRAM banks with one register stage. Optional XBAR_CONF_PORT_EN adds a priority config requester.
module crossbar_in #(
    parameter int NUM_PE     = 4,
    parameter int NUM_BANK   = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    crossbar_in_if.slave  bus
);
    localparam int BANK_W  = $clog2(NUM_BANK);
    localparam int BADDR_W = ADDR_WIDTH - BANK_W;
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int PTR_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
`ifdef XBAR_CONF_PORT_EN
    localparam int PEID_W  = NUM_PE + 1;
`else
    localparam int PEID_W  = NUM_PE;
`endif

    typedef logic [PTR_W-1:0] ptr_t;

    // PE index at priority position k when the search starts at base.
    function automatic ptr_t pe_at(input ptr_t base, input int k);
        int s;
        s = (int'(base) + k) % NUM_PE;
        return ptr_t'(s);
    endfunction

    logic [NUM_PE-1:0][BANK_W-1:0]        pe_bank;
    logic [NUM_BANK-1:0]                  conf_hit;
    logic [NUM_BANK-1:0]                  win_vld;
    ptr_t [NUM_BANK-1:0]                  win_pe;
    logic [NUM_PE-1:0]                    gnt;

    ptr_t [NUM_BANK-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [NUM_BANK-1:0]                  bank_en_q, bank_en_d;
    logic [NUM_BANK-1:0]                  bank_we_q, bank_we_d;
    logic [NUM_BANK-1:0][BADDR_W-1:0]     bank_addr_q, bank_addr_d;
    logic [NUM_BANK-1:0][DATA_WIDTH-1:0]  bank_wdata_q, bank_wdata_d;
    logic [NUM_BANK-1:0][STRB_W-1:0]      bank_wstrb_q, bank_wstrb_d;
    logic [NUM_BANK-1:0][PEID_W-1:0]      bank_peid_q, bank_peid_d;

    always_comb begin
        pe_bank = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            pe_bank[p] = bus.i_addr[p][BANK_W-1:0];
        end
    end

`ifdef XBAR_CONF_PORT_EN
    always_comb begin
        conf_hit = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            conf_hit[b] = bus.i_conf_req && (bus.i_conf_addr[BANK_W-1:0] == BANK_W'(b));
        end
    end

    assign bus.o_conf_gnt = bus.i_conf_req & ~i_rst;
`else
    assign conf_hit = '0;
`endif

    // A bank claimed by the config requester takes no PE winner this cycle.
    always_comb begin
        win_vld = '0;
        win_pe  = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (!conf_hit[b]) begin
                for (int k = 0; k < NUM_PE; k++) begin
                    if (!win_vld[b] && bus.i_req[pe_at(rr_ptr_q[b], k)] &&
                        (pe_bank[pe_at(rr_ptr_q[b], k)] == BANK_W'(b))) begin
                        win_vld[b] = 1'b1;
                        win_pe[b]  = pe_at(rr_ptr_q[b], k);
                    end
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (win_vld[b]) begin
                gnt[win_pe[b]] = 1'b1;
            end
        end
        if (i_rst) begin
            gnt = '0;
        end
    end

    assign bus.o_gnt = gnt;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (win_vld[b]) begin
                rr_ptr_d[b] = pe_at(win_pe[b], 1);
            end
        end
    end

    // Idle banks drop en/peID but keep their payload registers unchanged.
    always_comb begin
        bank_en_d    = '0;
        bank_peid_d  = '0;
        bank_we_d    = bank_we_q;
        bank_addr_d  = bank_addr_q;
        bank_wdata_d = bank_wdata_q;
        bank_wstrb_d = bank_wstrb_q;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (win_vld[b]) begin
                bank_en_d[b]               = 1'b1;
                bank_we_d[b]               = bus.i_we[win_pe[b]];
                bank_addr_d[b]             = bus.i_addr[win_pe[b]][ADDR_WIDTH-1:BANK_W];
                bank_wdata_d[b]            = bus.i_wdata[win_pe[b]];
                bank_wstrb_d[b]            = bus.i_wstrb[win_pe[b]];
                bank_peid_d[b][win_pe[b]]  = ~bus.i_we[win_pe[b]];
            end
`ifdef XBAR_CONF_PORT_EN
            if (conf_hit[b]) begin
                bank_en_d[b]               = 1'b1;
                bank_we_d[b]               = bus.i_conf_we;
                bank_addr_d[b]             = bus.i_conf_addr[ADDR_WIDTH-1:BANK_W];
                bank_wdata_d[b]            = bus.i_conf_wdata;
                bank_wstrb_d[b]            = bus.i_conf_wstrb;
                bank_peid_d[b][NUM_PE]     = ~bus.i_conf_we;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q     <= '0;
            bank_en_q    <= '0;
            bank_we_q    <= '0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            bank_wstrb_q <= '0;
            bank_peid_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            bank_en_q    <= bank_en_d;
            bank_we_q    <= bank_we_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
            bank_wstrb_q <= bank_wstrb_d;
            bank_peid_q  <= bank_peid_d;
        end
    end

    assign bus.o_bank_en    = bank_en_q;
    assign bus.o_bank_we    = bank_we_q;
    assign bus.o_bank_addr  = bank_addr_q;
    assign bus.o_bank_wdata = bank_wdata_q;
    assign bus.o_bank_wstrb = bank_wstrb_q;
    assign bus.o_bank_peID  = bank_peid_q;
    assign bus.o_dbg_rr_ptr = rr_ptr_q;
endmodule

// File: doc/crossbar_in.md
# crossbar_in

Request-side crossbar of the timelyRV instr/data memory: arbitrates read/write requests from `NUM_PE` requesters onto `NUM_BANK` word-interleaved SRAM banks.
- Each bank gets one registered request per cycle.
- Each bank also gets a one-hot per-bank PE bitmap (`o_bank_peID`), which the memory output crossbar consumes to steer read data back to the requesting PE.
- Sits between the core/PE memory ports and the SRAM banks; it is the mirror of the output crossbar.

## Interface
Parameters:
- `NUM_PE`, 4, number of requesters.
- `NUM_BANK`, 4, number of SRAM banks; power of two, ≥2.
- `ADDR_WIDTH`, 16, word-address width per requester.
- `DATA_WIDTH`, 32, write-data width; strobe width is `DATA_WIDTH/8`.

Ports (clock and reset first):
- `i_clk`  in  1  sole clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req`  in  [NUM_PE]  per-PE request valid.
- `i_we`  in  [NUM_PE]  1 = write, 0 = read.
- `i_addr`  in  [NUM_PE][ADDR_WIDTH]  word address.
- `i_wdata`  in  [NUM_PE][DATA_WIDTH]  write data.
- `i_wstrb`  in  [NUM_PE][DATA_WIDTH/8]  byte strobes.
- `o_gnt`  out  [NUM_PE]  combinational accept; the request is consumed in the cycle where `i_req & o_gnt`.
- `o_bank_en`  out  [NUM_BANK]  registered bank enable.
- `o_bank_we`  out  [NUM_BANK]  registered write enable.
- `o_bank_addr`  out  [NUM_BANK][ADDR_WIDTH-log2(NUM_BANK)]  in-bank address.
- `o_bank_wdata`  out  [NUM_BANK][DATA_WIDTH]  registered write data.
- `o_bank_wstrb`  out  [NUM_BANK][DATA_WIDTH/8]  registered strobes.
- `o_bank_peID`  out  [NUM_BANK][NUM_PE]  one-hot owner of a read; all-zero for writes and idle.

## Operation
- **Bank decode:** bank = `i_addr[log2(NUM_BANK)-1:0]`; in-bank address = `i_addr >> log2(NUM_BANK)`.
- **Per-bank arbiter:** round-robin among PEs requesting that bank.
  - Each bank holds a pointer `rr_ptr[b]` (reset 0). Priority starts at `rr_ptr[b]` and wraps modulo `NUM_PE`.
  - On a grant to PE p, `rr_ptr[b]` becomes (p+1) mod `NUM_PE`. With no grant, the pointer holds.
- **At most one grant per bank per cycle.** A PE targets exactly one bank, so it gets at most one grant.
- **Request holding:** the requester must keep `i_req` and its payload stable until granted. Dropping `i_req` before grant is legal (withdrawal) and leaves no state behind.
- **Register stage:** each winner's we/addr/wdata/wstrb are registered into the bank outputs. `o_bank_en[b]` is 1 in the following cycle.
- **peID bitmap:** `o_bank_peID[b]` has bit p set only for a granted read. For writes and idle banks it is 0, so the output crossbar raises no `o_valid` for writes.
- **Loser banks:** a bank with no winner drives `o_bank_en`=0 and `o_bank_peID`=0. Its data/addr/strobe outputs hold their last value (don't-care).

## Timing
- Grant latency: 0 cycles (`o_gnt` combinational from `i_req`, `i_addr`, `rr_ptr`).
- Grant in cycle T → bank outputs valid in T+1.
  - `o_bank_peID` is aligned with `o_bank_en` in the same cycle.
  - The output crossbar adds its own fixed delay for read data.
- Throughput: one access per bank per cycle; up to `min(NUM_PE, NUM_BANK)` accesses per cycle.
- **Reset** (sampled at `i_clk` edge while `i_rst`=1):
  - `o_bank_en`, `o_bank_we`, `o_bank_addr`, `o_bank_wdata`, `o_bank_wstrb`, `o_bank_peID` = 0; all `rr_ptr` = 0.
  - `o_gnt` = 0 while `i_rst` is high.
- **Reset mid-operation:** grants given in the reset cycle are dropped. Bank outputs are 0 in the cycle after reset is sampled.
- **Simultaneous conflicts:** losers see `o_gnt`=0 and retry next cycle. Under continuous contention each PE wins within `NUM_PE` cycles.
- **Pointer wrap:** a grant to PE `NUM_PE-1` sets the pointer to 0.

## Configuration
- **Macro `XBAR_CONF_PORT_EN`.**
- **Defined:** adds a configuration requester.
  - Ports: `i_conf_req`, `i_conf_we`, `i_conf_addr`, `i_conf_wdata`, `i_conf_wstrb`, `o_conf_gnt`.
  - It has absolute priority over all PEs on its target bank and does not advance `rr_ptr`.
  - `o_bank_peID` widens to `NUM_PE+1`; bit `NUM_PE` marks a configuration read.
- **Undefined:** ports absent, `o_bank_peID` is `NUM_PE` wide, and arbitration is pure round-robin.

## Test plan
- Reset: assert `i_rst` 2 cycles with all `i_req`=1 → `o_gnt`=0 throughout; all bank outputs 0; first grants go to the lowest-index PE per bank after release.
- No conflict: PE0 reads addr 0x0004 (bank 0), PE1 writes 0x0005 (bank 1) wstrb 0xF in cycle T → both granted in T.
  - T+1: bank0 en=1, we=0, addr=0x0001, peID=0001.
  - T+1: bank1 en=1, we=1, addr=0x0001, peID=0000.
- Full conflict: all 4 PEs read bank 2 continuously → grants PE0, PE1, PE2, PE3, PE0 on consecutive cycles; `o_bank_peID[2]` = 0001, 0010, 0100, 1000, 0001 one cycle later.
- Withdrawal: PE3 requests bank 1 and loses to PE0, then drops `i_req` → no later bank-1 access for PE3; `rr_ptr[1]`=1.
- Mid-run reset: grant PE2→bank 3 in cycle T with `i_rst`=1 in T → bank 3 en=0 in T+1 and pointer 0.
- With `XBAR_CONF_PORT_EN`: conf read and PE1 read both on bank 0 → conf granted, `o_bank_peID[0]`=10000, PE1 granted next cycle, `rr_ptr[0]` unchanged until then.
